// File: rtl/reaction_timer_if.sv
// Pin bundle of the reaction-time round controller.
// The timer drives the display-side outputs; the environment drives Start/Button.
interface reaction_timer_if;
  logic        Start;
  logic        Button;
  logic [12:0] Score;
  logic        Load;
  logic        Display;
  logic        Stimulus;
  logic        FalseStart;

  modport master (
    input  Start, Button,
    output Score, Load, Display, Stimulus, FalseStart
  );

  modport slave (
    output Start, Button,
    input  Score, Load, Display, Stimulus, FalseStart
  );
endinterface

// File: rtl/reaction_timer.sv
// Reaction-time game round controller with millisecond timer.
// Random pre-stimulus delay, false-start detection, registered score strobe.
module reaction_timer #(
  parameter int          CLKS_PER_MS  = 50000,
  parameter int          MIN_DELAY_MS = 1000,
  parameter int          MAX_SCORE    = 9999,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input logic Clock,
  input logic Reset,
  reaction_timer_if.master io
);

  localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam int DW = $clog2(MIN_DELAY_MS + 2049);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLKS_PER_MS - 1);
  localparam logic [12:0] SCORE_MAX  = 13'(MAX_SCORE);
  localparam logic [12:0] SCORE_LAST = 13'(MAX_SCORE - 1);

  if (MAX_SCORE > 8191) begin : g_bad_max
    $error("MAX_SCORE does not fit in 13 bits");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_ARMED, S_FALSE, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      st_sh_q, st_sh_d;
  logic [2:0]      bt_sh_q, bt_sh_d;
  logic            start_ev_q, start_ev_d;
  logic            btn_ev_q, btn_ev_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [DW-1:0]   delay_q, delay_d;
  logic [12:0]     ms_q, ms_d;
  logic [12:0]     score_q, score_d;
  logic            load_q, load_d;
  logic            disp_q, disp_d;
  logic            stim_q, stim_d;
  logic            fs_q, fs_d;
  logic            tick;

  // sh[0]/sh[1] synchronize, sh[2] holds the previous level for edge detect
  always_comb begin
    st_sh_d    = {st_sh_q[1:0], io.Start};
    bt_sh_d    = {bt_sh_q[1:0], io.Button};
    start_ev_d = st_sh_q[1] & ~st_sh_q[2];
    btn_ev_d   = bt_sh_q[1] & ~bt_sh_q[2];
    lfsr_d     = {lfsr_q[14:0],
                  lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign tick = (presc_q == PRESC_MAX);

  always_comb begin
    state_d = state_q;
    presc_d = tick ? '0 : presc_q + PW'(1);
    delay_d = delay_q;
    ms_d    = ms_q;
    score_d = score_q;
    load_d  = 1'b0;
    disp_d  = disp_q;
    stim_d  = stim_q;
    fs_d    = fs_q;
    unique case (state_q)
      S_IDLE, S_FALSE, S_DONE: begin
        if (start_ev_q) begin
          delay_d = DW'(MIN_DELAY_MS) + DW'(lfsr_q[10:0]);
          fs_d    = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (tick) delay_d = delay_q - DW'(1);
        if (btn_ev_q) begin
          score_d = '0;
          load_d  = 1'b1;
          fs_d    = 1'b1;
          stim_d  = 1'b0;
          state_d = S_FALSE;
        end else if (tick && delay_q == DW'(1)) begin
          stim_d  = 1'b1;
          ms_d    = '0;
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (tick) ms_d = ms_q + 13'd1;
        if (btn_ev_q) begin
          score_d = ms_q;
          load_d  = 1'b1;
          stim_d  = 1'b0;
          state_d = S_DONE;
        end else if (tick && ms_q == SCORE_LAST) begin
          score_d = SCORE_MAX;
          load_d  = 1'b1;
          stim_d  = 1'b0;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load_d) disp_d = 1'b1;
    // every state entry restarts the ms grid
    if (state_d != state_q) presc_d = '0;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      st_sh_q    <= '0;
      bt_sh_q    <= '0;
      start_ev_q <= 1'b0;
      btn_ev_q   <= 1'b0;
      lfsr_q     <= LFSR_SEED;
      presc_q    <= '0;
      delay_q    <= '0;
      ms_q       <= '0;
      score_q    <= '0;
      load_q     <= 1'b0;
      disp_q     <= 1'b0;
      stim_q     <= 1'b0;
      fs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      st_sh_q    <= st_sh_d;
      bt_sh_q    <= bt_sh_d;
      start_ev_q <= start_ev_d;
      btn_ev_q   <= btn_ev_d;
      lfsr_q     <= lfsr_d;
      presc_q    <= presc_d;
      delay_q    <= delay_d;
      ms_q       <= ms_d;
      score_q    <= score_d;
      load_q     <= load_d;
      disp_q     <= disp_d;
      stim_q     <= stim_d;
      fs_q       <= fs_d;
    end
  end

  assign io.Score      = score_q;
  assign io.Load       = load_q;
  assign io.Display    = disp_q;
  assign io.Stimulus   = stim_q;
  assign io.FalseStart = fs_q;

endmodule
